// File: rtl/rob_commit.sv
// In-order commit stage: retires the ROB head and updates the retirement map.
// Stores first hand off to the LSQ and then wait for its acknowledge before they retire.
module rob_commit #(
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int ARCH_REG_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rob_empty,
    input  logic                      head_ready,
    input  logic                      head_store,
    input  logic                      head_regwrite,
    input  logic [ARCH_REG_WIDTH-1:0] head_rd,
    input  logic [PHYS_REG_WIDTH-1:0] head_pd,
    output logic                      rob_ren,
    output logic                      st_commit_req,
    input  logic                      st_commit_ack,
    output logic                      rrf_we,
    output logic [ARCH_REG_WIDTH-1:0] rrf_rd,
    output logic [PHYS_REG_WIDTH-1:0] rrf_pd,
    output logic                      free_we,
    output logic [PHYS_REG_WIDTH-1:0] free_pd,
    input  logic [ARCH_REG_WIDTH-1:0] rrf_raddr,
    output logic [PHYS_REG_WIDTH-1:0] rrf_rdata,
    output logic [63:0]               instret
);

    localparam int NUM_ARCH = 2 ** ARCH_REG_WIDTH;

    typedef enum logic {
        IDLE,
        ST_WAIT
    } state_t;

    state_t                    state;
    logic [PHYS_REG_WIDTH-1:0] rrf [NUM_ARCH];
    logic                      commit_ok;
    logic                      map_write;

    assign commit_ok     = ~rob_empty & head_ready;
    assign st_commit_req = (state == ST_WAIT);
    assign rrf_rdata     = rrf[rrf_raddr];

    // Gating with rst keeps every commit output quiet while reset is held.
    always_comb begin
        rob_ren = 1'b0;
        if (rst) begin
            case (state)
                IDLE:    rob_ren = commit_ok & ~head_store;
                ST_WAIT: rob_ren = st_commit_ack;
                default: rob_ren = 1'b0;
            endcase
        end
    end

    assign map_write = rob_ren & head_regwrite & (head_rd != '0);

    always_comb begin
        rrf_we  = map_write;
        free_we = map_write;
        rrf_rd  = '0;
        rrf_pd  = '0;
        free_pd = '0;
        if (map_write) begin
            rrf_rd  = head_rd;
            rrf_pd  = head_pd;
            free_pd = rrf[head_rd];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            instret <= '0;
            for (int i = 0; i < NUM_ARCH; i++) begin
                rrf[i] <= PHYS_REG_WIDTH'(i);
            end
        end else begin
            case (state)
                IDLE:    if (commit_ok && head_store) state <= ST_WAIT;
                ST_WAIT: if (st_commit_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (rob_ren) begin
                instret <= instret + 64'd1;
            end
            if (map_write) begin
                rrf[head_rd] <= head_pd;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: fixed vector tables for the named scenarios, then random traffic
// compared against a simple retirement model.
module tb_rob_commit;

    typedef struct {
        int empty, ready, store, rw, rd, pd, ack, raddr;
        int e_ren, e_rwe, e_rrd, e_rpd, e_fwe, e_fpd, e_req, e_rdata, e_inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rob_empty = 1'b1, head_ready = 1'b0, head_store = 1'b0, head_regwrite = 1'b0;
    logic [4:0]  head_rd = '0;
    logic [5:0]  head_pd = '0;
    logic        st_commit_ack = 1'b0;
    logic [4:0]  rrf_raddr = '0;
    logic        rob_ren, st_commit_req, rrf_we, free_we;
    logic [4:0]  rrf_rd;
    logic [5:0]  rrf_pd, free_pd, rrf_rdata;
    logic [63:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    int     m_rrf [32];
    bit     m_wait;
    longint m_inst;

    vec_t tbl [11];
    vec_t st_seq [6];

    rob_commit #(.ROB_ADDR_WIDTH(4), .PHYS_REG_WIDTH(6), .ARCH_REG_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .rob_empty(rob_empty), .head_ready(head_ready), .head_store(head_store),
        .head_regwrite(head_regwrite), .head_rd(head_rd), .head_pd(head_pd),
        .rob_ren(rob_ren), .st_commit_req(st_commit_req), .st_commit_ack(st_commit_ack),
        .rrf_we(rrf_we), .rrf_rd(rrf_rd), .rrf_pd(rrf_pd),
        .free_we(free_we), .free_pd(free_pd),
        .rrf_raddr(rrf_raddr), .rrf_rdata(rrf_rdata), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rob_empty     = v.empty[0];
        head_ready    = v.ready[0];
        head_store    = v.store[0];
        head_regwrite = v.rw[0];
        head_rd       = 5'(v.rd);
        head_pd       = 6'(v.pd);
        st_commit_ack = v.ack[0];
        rrf_raddr     = 5'(v.raddr);
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        check({tag, ".rob_ren"},   longint'(rob_ren),       longint'(v.e_ren));
        check({tag, ".rrf_we"},    longint'(rrf_we),        longint'(v.e_rwe));
        check({tag, ".rrf_rd"},    longint'(rrf_rd),        longint'(v.e_rrd));
        check({tag, ".rrf_pd"},    longint'(rrf_pd),        longint'(v.e_rpd));
        check({tag, ".free_we"},   longint'(free_we),       longint'(v.e_fwe));
        check({tag, ".free_pd"},   longint'(free_pd),       longint'(v.e_fpd));
        check({tag, ".st_req"},    longint'(st_commit_req), longint'(v.e_req));
        check({tag, ".rrf_rdata"}, longint'(rrf_rdata),     longint'(v.e_rdata));
        check({tag, ".instret"},   longint'(instret),       longint'(v.e_inst));
    endtask

    // Inputs change just after a rising edge, outputs are sampled on the falling edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        drive(v);
        #4;
        checkOutput(tag, v);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rrf[i] = i;
        m_wait = 1'b0;
        m_inst = 0;
    endtask

    task automatic do_reset();
        vec_t z;
        z = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(z);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic vec_t model_expect(input vec_t v);
        vec_t r;
        bit   retire, maps;
        r = v;
        if (m_wait) retire = (v.ack != 0);
        else        retire = (v.empty == 0) && (v.ready != 0) && (v.store == 0);
        maps      = retire && (v.rw != 0) && (v.rd != 0);
        r.e_ren   = int'(retire);
        r.e_rwe   = int'(maps);
        r.e_fwe   = int'(maps);
        r.e_rrd   = maps ? v.rd : 0;
        r.e_rpd   = maps ? v.pd : 0;
        r.e_fpd   = maps ? m_rrf[v.rd] : 0;
        r.e_req   = int'(m_wait);
        r.e_rdata = m_rrf[v.raddr];
        r.e_inst  = int'(m_inst);
        return r;
    endfunction

    task automatic model_update(input vec_t r);
        if (r.e_ren != 0) m_inst++;
        if (r.e_rwe != 0) m_rrf[r.rd] = r.pd;
        if (m_wait) begin
            if (r.ack != 0) m_wait = 1'b0;
        end else if (r.empty == 0 && r.ready != 0 && r.store != 0) begin
            m_wait = 1'b1;
        end
    endtask

    initial begin
        vec_t v;

        // fields: empty ready store rw rd pd ack raddr | ren rwe rrd rpd fwe fpd req rdata inst
        tbl[0]  = '{1, 1, 0, 1, 5, 40, 0, 5,  0, 0, 0, 0,  0, 0,  0, 5,  0};
        tbl[1]  = '{0, 1, 0, 1, 5, 40, 0, 5,  1, 1, 5, 40, 1, 5,  0, 5,  0};
        tbl[2]  = '{0, 0, 0, 1, 5, 40, 0, 5,  0, 0, 0, 0,  0, 0,  0, 40, 1};
        tbl[3]  = '{0, 1, 0, 1, 7, 50, 0, 7,  1, 1, 7, 50, 1, 7,  0, 7,  1};
        tbl[4]  = '{0, 1, 0, 1, 7, 51, 0, 7,  1, 1, 7, 51, 1, 50, 0, 50, 2};
        tbl[5]  = '{0, 0, 0, 1, 7, 51, 0, 7,  0, 0, 0, 0,  0, 0,  0, 51, 3};
        tbl[6]  = '{0, 1, 0, 1, 0, 33, 0, 0,  1, 0, 0, 0,  0, 0,  0, 0,  3};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  4};
        tbl[8]  = '{0, 1, 0, 0, 9, 44, 0, 9,  1, 0, 0, 0,  0, 0,  0, 9,  4};
        tbl[9]  = '{0, 0, 0, 0, 9, 44, 1, 9,  0, 0, 0, 0,  0, 0,  0, 9,  5};
        tbl[10] = '{0, 0, 0, 0, 0, 0,  0, 5,  0, 0, 0, 0,  0, 0,  0, 40, 5};

        st_seq[0] = '{0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        st_seq[1] = '{1, 0, 0, 1, 6, 9, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
        st_seq[2] = '{0, 1, 0, 1, 6, 9, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
        st_seq[3] = '{0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
        st_seq[4] = '{0, 1, 1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0};
        st_seq[5] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1};

        do_reset();
        for (int i = 0; i < 11; i++) applyStimulus($sformatf("tbl%0d", i), tbl[i]);

        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus($sformatf("store%0d", i), st_seq[i]);

        // Reset arriving while a store waits for its acknowledge.
        do_reset();
        v = '{0, 1, 0, 1, 3, 60, 0, 3,  1, 1, 3, 60, 1, 3, 0, 3, 0};
        applyStimulus("rw_alu", v);
        v = '{0, 1, 1, 0, 0, 0, 0, 3,   0, 0, 0, 0, 0, 0, 0, 60, 1};
        applyStimulus("rw_store", v);
        v = '{0, 1, 0, 1, 4, 20, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(v);
        #1;
        check("rw_wait.st_req", longint'(st_commit_req), 1);
        #1;
        rst = 1'b0;
        #1;
        check("rw_rst.st_req",    longint'(st_commit_req), 0);
        check("rw_rst.rob_ren",   longint'(rob_ren), 0);
        check("rw_rst.rrf_we",    longint'(rrf_we), 0);
        check("rw_rst.free_we",   longint'(free_we), 0);
        check("rw_rst.rrf_rd",    longint'(rrf_rd), 0);
        check("rw_rst.rrf_pd",    longint'(rrf_pd), 0);
        check("rw_rst.free_pd",   longint'(free_pd), 0);
        check("rw_rst.instret",   longint'(instret), 0);
        check("rw_rst.rrf_rdata", longint'(rrf_rdata), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        v = '{0, 1, 0, 1, 4, 20, 1, 3,  1, 1, 4, 20, 1, 4, 0, 3, 0};
        applyStimulus("rw_first", v);
        v = '{0, 0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 0, 0, 0, 20, 1};
        applyStimulus("rw_after", v);

        do_reset();
        for (int c = 0; c < 600; c++) begin
            v.empty = int'($urandom_range(0, 3) == 0);
            v.ready = int'($urandom_range(0, 3) != 0);
            v.store = int'($urandom_range(0, 3) == 0);
            v.rw    = int'($urandom_range(0, 4) != 0);
            v.rd    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            v.pd    = int'($urandom_range(0, 63));
            v.ack   = int'($urandom_range(0, 2) == 0);
            v.raddr = int'($urandom_range(0, 31));
            v = model_expect(v);
            applyStimulus($sformatf("rnd%0d", c), v);
            model_update(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter ROB_ADDR_WIDTH, default 4, log2 of ROB depth.
REQ-002 Parameter PHYS_REG_WIDTH, default 6, physical register tag width.
REQ-003 Parameter ARCH_REG_WIDTH, default 5, architectural register index width (32 arch regs).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 rob_empty  in  1  ROB has no entries.
REQ-007 head_ready  in  1  ROB head entry has completed.
REQ-008 head_store  in  1  head entry is a store.
REQ-009 head_regwrite  in  1  head entry writes a destination register.
REQ-010 head_rd  in  ARCH_REG_WIDTH  head architectural destination.
REQ-011 head_pd  in  PHYS_REG_WIDTH  head physical destination.
REQ-012 rob_ren  out  1  dequeue head this cycle.
REQ-013 st_commit_req  out  1  request LSQ to perform head store to memory.
REQ-014 st_commit_ack  in  1  LSQ reports store performed.
REQ-015 rrf_we / rrf_rd / rrf_pd  out  1 / ARCH_REG_WIDTH / PHYS_REG_WIDTH  retirement map update, mirrored to the rename stage.
REQ-016 free_we / free_pd  out  1 / PHYS_REG_WIDTH  release of superseded physical register to the free list.
REQ-017 rrf_raddr  in  ARCH_REG_WIDTH; rrf_rdata  out  PHYS_REG_WIDTH  combinational read of the retirement map for recovery.
REQ-018 instret  out  64  count of committed instructions.

Function
REQ-019 Block SHALL hold a 32-entry retirement map RRF[arch] -> phys and a two-state FSM {IDLE, ST_WAIT}.
REQ-020 commit_ok SHALL be defined as ~rob_empty & head_ready.
REQ-021 IDLE, commit_ok & ~head_store: rob_ren=1 combinationally in the same cycle (zero-cycle commit); FSM stays IDLE.
REQ-022 IDLE, commit_ok & head_store: rob_ren=0; FSM -> ST_WAIT at next edge.
REQ-023 st_commit_req SHALL be 1 exactly while FSM is ST_WAIT (registered, no combinational input path).
REQ-024 ST_WAIT & st_commit_ack: rob_ren=1 same cycle; FSM -> IDLE at next edge; minimum store commit latency 2 cycles from head ready.
REQ-025 ST_WAIT & ~st_commit_ack: hold ST_WAIT indefinitely, rob_ren=0, inputs other than ack ignored.
REQ-026 st_commit_ack outside ST_WAIT SHALL be ignored.
REQ-027 On every cycle with rob_ren=1 and head_regwrite=1 and head_rd!=0: rrf_we=1, rrf_rd=head_rd, rrf_pd=head_pd, free_we=1, free_pd=RRF[head_rd] (value before update); RRF[head_rd]<=head_pd at the edge.
REQ-028 head_rd==0 or head_regwrite==0: rrf_we=0, free_we=0, RRF unchanged, commit still occurs.
REQ-029 rrf_we, rrf_rd, rrf_pd, free_we, free_pd SHALL be combinational with rob_ren; when rrf_we/free_we=0 the data outputs SHALL be 0.
REQ-030 At most one commit per cycle.
REQ-031 instret SHALL increment by 1 at each edge where rob_ren=1; wraps modulo 2^64.
REQ-032 rrf_rdata=RRF[rrf_raddr], reflecting pre-edge contents; same-cycle update is not bypassed.
REQ-033 rob_empty=1 SHALL force rob_ren=0 in IDLE regardless of head_* inputs.

Reset
REQ-034 While rst=0, asynchronously: FSM=IDLE, RRF[i]=i for i=0..31, instret=0, st_commit_req=0.
REQ-035 Combinational outputs SHALL be 0 during reset (rob_ren, rrf_we, free_we, data outputs).
REQ-036 Reset asserted in ST_WAIT SHALL abandon the pending store request; no ack is awaited after release.
REQ-037 First commit possible on the first rising edge after rst deasserts.

Verification
REQ-038 ALU op head_ready=1, store=0, rd=5, pd=40 after reset -> same cycle rob_ren=1, rrf_we=1 rd=5 pd=40, free_we=1 free_pd=5; next cycle rrf_rdata(raddr=5)=40, instret=1.
REQ-039 Store at head, ack held 0 for 3 cycles then 1 -> st_commit_req high from cycle 1 through ack cycle, rob_ren=1 only in ack cycle, FSM IDLE after, rrf_we=0.
REQ-040 rd=0 regwrite=1 pd=33 -> rob_ren=1, rrf_we=0, free_we=0, RRF[0]=0.
REQ-041 Back-to-back writes rd=7 pd=50 then rd=7 pd=51 -> second commit free_pd=50, RRF[7]=51, instret=2.
REQ-042 rob_empty=1 with head_ready=1 -> rob_ren=0, no state change; rst pulsed low in ST_WAIT -> st_commit_req=0 immediately, RRF identity, instret=0.
